pc_sequencer: RTL

Fetch-side controller for the program counter. Owns the PC register, sequences instruction-memory requests with a req/ack handshake, and chooses each next PC. Sources are the boot address, sequential +4, branch target, jump target and trap vector. It sits between the decode/execute stages, which supply redirects and stalls, and instruction memory, and feeds the fetched PC to decode.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_redirect_mux.sv | 55 +++++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        STALLED = 2'd2,
        HALTED  = 2'd3
    } seq_state_t;

    // Encoded so that a larger value means a higher redirect priority.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        TRAP   = 2'd3
    } redir_src_t;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select between a latched (pending) redirect and the redirects
// arriving this cycle. Priority is trap > jump > branch; on equal priority
// the newer arrival wins. The selected target is word aligned.
module pc_redirect_mux
    import pc_seq_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
    input  logic             pend_valid,
    input  redir_src_t       pend_src,
    input  logic [XLEN-1:0]  pend_target,
    input  logic             branch_valid,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             trap,
    output logic             sel_valid,
    output redir_src_t       sel_src,
    output logic [XLEN-1:0]  sel_target
);

    redir_src_t      arrive_src;
    logic [XLEN-1:0] arrive_target;
    logic [XLEN-1:0] raw_target;

    // Pick the highest-priority arriving redirect.
    always_comb begin
        arrive_src    = NONE;
        arrive_target = '0;
        if (trap) begin
            arrive_src    = TRAP;
            arrive_target = TRAP_VEC;
        end else if (jump_valid) begin
            arrive_src    = JUMP;
            arrive_target = jump_target;
        end else if (branch_valid) begin
            arrive_src    = BRANCH;
            arrive_target = branch_target;
        end
    end

    // Keep the pending redirect only if it strictly outranks the arrival.
    always_comb begin
        sel_src    = arrive_src;
        raw_target = arrive_target;
        if (pend_valid && (pend_src > arrive_src)) begin
            sel_src    = pend_src;
            raw_target = pend_target;
        end
        sel_valid  = (sel_src != NONE);
        sel_target = raw_target & ~XLEN'(3);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: owns the PC, drives the instruction-memory
// req/ack handshake and selects the next PC (boot, +4, branch, jump, trap).
//
// state   | meaning
// --------+-----------------------------------------------------------
// BOOT    | one cycle after reset, loads the aligned boot address
// FETCH   | imem_req high, waiting for / completing imem_ack
// STALLED | downstream busy, no request; redirects update pc directly
// HALTED  | fetching stopped until reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [XLEN-1:0]  startPC,
    input  logic             branch_valid,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             trap,
    input  logic             stall,
    input  logic             halt,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  fetch_pc
);

    seq_state_t      state,       state_nx;
    logic [XLEN-1:0] pc,          pc_nx;
    logic            pend_valid,  pend_valid_nx;
    redir_src_t      pend_src,    pend_src_nx;
    logic [XLEN-1:0] pend_target, pend_target_nx;
    logic            fetch_valid_nx;
    logic [XLEN-1:0] fetch_pc_nx;

    logic            sel_valid;
    redir_src_t      sel_src;
    logic [XLEN-1:0] sel_target;

    pc_redirect_mux #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_redirect_mux (
        .pend_valid    (pend_valid),
        .pend_src      (pend_src),
        .pend_target   (pend_target),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .trap          (trap),
        .sel_valid     (sel_valid),
        .sel_src       (sel_src),
        .sel_target    (sel_target)
    );

    assign imem_addr = pc;

    // State, PC, pending redirect and fetch output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= BOOT;
            pc          <= '0;
            pend_valid  <= 1'b0;
            pend_src    <= NONE;
            pend_target <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pend_valid  <= pend_valid_nx;
            pend_src    <= pend_src_nx;
            pend_target <= pend_target_nx;
            fetch_valid <= fetch_valid_nx;
            fetch_pc    <= fetch_pc_nx;
        end
    end

    // Next-state, next-PC and request logic.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pend_valid_nx  = pend_valid;
        pend_src_nx    = pend_src;
        pend_target_nx = pend_target;
        fetch_valid_nx = 1'b0;
        fetch_pc_nx    = fetch_pc;
        imem_req       = 1'b0;

        case (state)
            BOOT: begin
                pc_nx    = startPC & ~XLEN'(3);
                state_nx = halt ? HALTED : FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (sel_valid) begin
                        // Word at the old address is killed.
                        pc_nx          = sel_target;
                        pend_valid_nx  = 1'b0;
                        pend_src_nx    = NONE;
                    end else begin
                        fetch_valid_nx = 1'b1;
                        fetch_pc_nx    = pc;
                        pc_nx          = pc + XLEN'(PC_INC);
                    end
                    if (halt) begin
                        state_nx = HALTED;
                    end else if (stall) begin
                        state_nx = STALLED;
                    end
                end else if (sel_valid) begin
                    // Request stays in flight; remember the redirect for its ack.
                    pend_valid_nx  = 1'b1;
                    pend_src_nx    = sel_src;
                    pend_target_nx = sel_target;
                end
            end

            STALLED: begin
                if (sel_valid) begin
                    pc_nx = sel_target;
                end
                if (halt) begin
                    state_nx = HALTED;
                end else if (!stall) begin
                    state_nx = FETCH;
                end
            end

            HALTED: begin
                state_nx = HALTED;
            end

            default: begin
                state_nx = BOOT;
            end
        endcase
    end

endmodule
